// File: rtl/xsleena_vram_slot_arbiter_pkg.sv
// xsleena_pkg: shared state type, slot owner codes and default widths for the VRAM slot arbiter
package xsleena_pkg;

    localparam int DEF_AW = 11;
    localparam int DEF_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        VID_RD,
        VID_LAT,
        CPU_RD,
        CPU_WR,
        CPU_LAT,
        CLR_WR
    } vram_arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU,
        OWN_CLR
    } slot_owner_t;

    // Fixed priority: video (outside vblank), then CPU, then the clear engine.
    function automatic slot_owner_t slot_owner(input logic vid, input logic vblk, input logic req, input logic busy);
        if (vid & ~vblk) return OWN_VID;
        if (req) return OWN_CPU;
        if (busy) return OWN_CLR;
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/xsleena_vram_slot_arbiter_if.sv
// xsleena_vram_slot_arbiter_if: CPU request/ack bus between the host interface and the VRAM arbiter
interface xsleena_vram_slot_arbiter_if #(
    parameter int AW = xsleena_pkg::DEF_AW,
    parameter int DW = xsleena_pkg::DEF_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_ack;
    logic          cpu_wait;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack, cpu_wait
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack, cpu_wait
    );
endinterface

// File: rtl/xsleena_vram_slot_arbiter_clr_counter.sv
// xsleena_clr_counter: clear-engine address counter; busy from load until the write at the last address
module xsleena_clr_counter #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    output logic [AW-1:0] cnt,
    output logic          busy
);
    logic tc;

    assign tc = &cnt;

    // Restart wins over a step in the same cycle; the counter wraps to 0 after the last address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= '0;
            busy <= 1'b1;
        end else if (step) begin
            cnt  <= cnt + 1'b1;
            busy <= ~tc;
        end
    end
endmodule

// File: rtl/xsleena_vram_slot_arbiter.sv
// xsleena_vram_slot_arbiter: time-slot sharing of one single-port VRAM between video, CPU and clear engine
module xsleena_vram_slot_arbiter
    import xsleena_pkg::*;
#(
    parameter int            AW      = DEF_AW,
    parameter int            DW      = DEF_DW,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          slot_stb,
    input  logic          slot_vid,
    input  logic          VBLK,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,
    xsleena_vram_slot_arbiter_if.slave cpu,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          overrun
);
    vram_arb_state_t state, state_nxt;
    slot_owner_t     owner;
    logic [AW-1:0]   clr_addr;
    logic [DW-1:0]   vid_q, cpu_q;
    logic            ack;

    assign owner        = slot_owner(slot_vid, VBLK, cpu.cpu_req, clr_busy);
    assign cpu.cpu_ack  = ack;
    assign cpu.cpu_wait = cpu.cpu_req & ~ack;

    xsleena_clr_counter #(.AW(AW)) u_clr (
        .clk   (clk),
        .rst   (RST),
        .start (clr_start),
        .step  (state == CLR_WR),
        .cnt   (clr_addr),
        .busy  (clr_busy)
    );

    // Next slot owner on a strobe in IDLE; pulses and write enable are decoded from the state register.
    always_comb begin
        state_nxt = state;
        ram_we    = (state == CPU_WR) || (state == CLR_WR);
        vid_valid = state == VID_LAT;
        ack       = (state == CPU_WR) || (state == CPU_LAT);
        // The RAM output register is the data source in the latch cycle; the local copy holds it afterwards.
        vid_dout     = (state == VID_LAT) ? ram_dout : vid_q;
        cpu.cpu_dout = (state == CPU_LAT) ? ram_dout : cpu_q;
        case (state)
            IDLE: begin
                if (slot_stb) begin
                    if (owner == OWN_VID) state_nxt = VID_RD;
                    else if (owner == OWN_CPU) state_nxt = cpu.cpu_we ? CPU_WR : CPU_RD;
                    else if (owner == OWN_CLR) state_nxt = CLR_WR;
                end
            end
            VID_RD:  state_nxt = VID_LAT;
            CPU_RD:  state_nxt = CPU_LAT;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, RAM address/data launch on slot grant, read-data capture and sticky overrun.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ram_addr <= '0;
            ram_din  <= '0;
            vid_q    <= '0;
            cpu_q    <= '0;
            overrun  <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= overrun | (slot_stb & (state != IDLE));
            if (state_nxt == VID_RD) ram_addr <= vid_addr;
            if (state_nxt == CPU_RD || state_nxt == CPU_WR) ram_addr <= cpu.cpu_addr;
            if (state_nxt == CPU_WR) ram_din <= cpu.cpu_din;
            if (state_nxt == CLR_WR) begin
                ram_addr <= clr_addr;
                ram_din  <= CLR_VAL;
            end
            if (state == VID_LAT) vid_q <= ram_dout;
            if (state == CPU_LAT) cpu_q <= ram_dout;
        end
    end
endmodule
